// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit count, result width, digit type and the
// converter state encoding. Also used by the binary-to-BCD display block.
package bcd_pkg;

  localparam int DIGITS    = 9;
  localparam int BIN_WIDTH = 30;
  localparam int IDX_W     = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [DIGITS-1:0] bcd_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } bcd_state_t;

  // True when any digit of the word lies outside 0..9.
  function automatic logic any_bad_digit(input bcd_word_t w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[i] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit using two shifts and two adds.
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [BIN_WIDTH-1:0] acc_i,
  input  bcd_digit_t           digit_i,
  output logic [BIN_WIDTH-1:0] acc_o
);

  // Sum is formed four bits wider and truncated; the top bits are only
  // reachable with non-decimal digits, whose result is discarded anyway.
  assign acc_o = BIN_WIDTH'(({4'b0000, acc_i} << 3)
                          + ({4'b0000, acc_i} << 1)
                          + {{BIN_WIDTH{1'b0}}, digit_i});

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential 9-digit BCD to 30-bit binary converter, one digit per clock,
// most-significant digit first, with a one-cycle done pulse and error flag.
module bcd_to_binary_seq
  import bcd_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 enable,
  input  logic [3:0]           BCD0,
  input  logic [3:0]           BCD1,
  input  logic [3:0]           BCD2,
  input  logic [3:0]           BCD3,
  input  logic [3:0]           BCD4,
  input  logic [3:0]           BCD5,
  input  logic [3:0]           BCD6,
  input  logic [3:0]           BCD7,
  input  logic [3:0]           BCD8,
  output logic [BIN_WIDTH-1:0] binary,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  bcd_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BIN_WIDTH-1:0] acc_q, acc_d;
  bcd_word_t            cap_q, cap_d;
  logic                 err_q, err_d;
  logic [BIN_WIDTH-1:0] binary_q, binary_d;
  logic                 error_q, error_d;
  logic                 done_q, done_d;
  logic [BIN_WIDTH-1:0] mac_acc;

  bcd_mac10 u_mac (
    .acc_i   (acc_q),
    .digit_i (cap_q[idx_q]),
    .acc_o   (mac_acc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    cap_d    = cap_q;
    err_d    = err_q;
    binary_d = binary_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          cap_d   = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
          acc_d   = '0;
          err_d   = 1'b0;
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        err_d   = err_q | any_bad_digit(cap_q);
        state_d = CONV;
      end
      CONV: begin
        acc_d = mac_acc;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        binary_d = err_q ? '0 : acc_q;
        error_d  = err_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, accumulator and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      binary_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      binary_q <= binary_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  // Digit capture register; only ever read after a fresh capture
  always_ff @(posedge Clk) begin
    cap_q <= cap_d;
  end

  assign busy   = (state_q == LOAD) || (state_q == CONV);
  assign done   = done_q;
  assign binary = binary_q;
  assign error  = error_q;

endmodule
